// File: rtl/scan_chain_loader_pkg.sv
// Shared types and helpers for the scan chain loader.
package scan_chain_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Counter width for a chain of n cells, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/scan_shreg.sv
// Parallel-load, serial-shift register shifting toward the MSB; serial_o is the MSB.
module scan_shreg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             serial_i,
  output logic             serial_o,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] data;
  logic [Width-1:0] data_next;
  logic [Width-1:0] shifted;

  if (Width == 1) begin : g_single
    assign shifted = serial_i;
  end else begin : g_multi
    assign shifted = {data[Width-2:0], serial_i};
  end

  always_comb begin
    data_next = data;
    if (load_i) begin
      data_next = load_data_i;
    end else if (shift_i) begin
      data_next = shifted;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data <= '0;
    end else begin
      data <= data_next;
    end
  end

  assign serial_o = data[Width-1];
  assign data_o   = data;

endmodule

// File: rtl/scan_chain_loader.sv
// Shifts a parallel word MSB-first into a scan chain while capturing the
// chain's previous contents from its tail.
module scan_chain_loader
  import scan_chain_loader_pkg::*;
#(
  parameter int unsigned ChainLength = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_valid_i,
  output logic                   load_ready_o,
  input  logic [ChainLength-1:0] load_data_i,
  output logic                   scan_en_o,
  output logic                   scan_d_o,
  input  logic                   scan_q_i,
  output logic                   capture_valid_o,
  input  logic                   capture_ready_i,
  output logic [ChainLength-1:0] capture_data_o,
  output logic                   busy_o
);

  localparam int unsigned CntWidth = cnt_width(ChainLength);

  state_e                state, state_next;
  logic [CntWidth-1:0]   cnt, cnt_next;
  logic                  scan_en;
  logic                  in_idle, in_shift, accept, last;
  logic                  ser_msb;
  logic [ChainLength-1:0] ser_data_unused;
  logic                  cap_serial_unused;

  assign in_idle  = (state == StIdle);
  assign in_shift = (state == StShift);
  assign accept   = in_idle & load_valid_i;
  assign last     = (cnt == CntWidth'(ChainLength - 1));

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    load_ready_o    = 1'b0;
    capture_valid_o = 1'b0;
    unique case (state)
      StIdle: begin
        load_ready_o = 1'b1;
        if (load_valid_i) begin
          state_next = StShift;
          cnt_next   = '0;
        end
      end
      StShift: begin
        cnt_next = cnt + 1'b1;
        if (last) begin
          state_next = StDone;
          cnt_next   = '0;
        end
      end
      StDone: begin
        capture_valid_o = 1'b1;
        if (capture_ready_i) begin
          state_next = StIdle;
        end
      end
      default: state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= StIdle;
      cnt     <= '0;
      scan_en <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      scan_en <= (state_next == StShift);
    end
  end

  // Both operands are flops, so scan_d_o is stable for the whole shift cycle.
  assign scan_en_o = scan_en;
  assign scan_d_o  = scan_en & ser_msb;
  assign busy_o    = !in_idle;

  scan_shreg #(
    .Width(ChainLength)
  ) u_load_ser (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (accept),
    .load_data_i(load_data_i),
    .shift_i    (in_shift),
    .serial_i   (1'b0),
    .serial_o   (ser_msb),
    .data_o     (ser_data_unused)
  );

  // Tail bits arrive oldest-position-first, so after N shifts bit k is position k.
  scan_shreg #(
    .Width(ChainLength)
  ) u_capture_deser (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (accept),
    .load_data_i('0),
    .shift_i    (in_shift),
    .serial_i   (scan_q_i),
    .serial_o   (cap_serial_unused),
    .data_o     (capture_data_o)
  );

endmodule

// File: tb/tb_scan_chain_loader.sv
// Directed bench for scan_chain_loader with N=8 and N=1 instances and chain models.
module tb_scan_chain_loader;

  logic clk;
  logic rst_n;

  // N = 8 instance
  logic       load_valid, load_ready, scan_en, scan_d, scan_q;
  logic       cap_valid, cap_ready, busy;
  logic [7:0] load_data, cap_data;
  logic [7:0] chain, chain_val;
  logic       chain_load;

  // N = 1 instance
  logic       load_valid1, load_ready1, scan_en1, scan_d1, scan_q1;
  logic       cap_valid1, cap_ready1, busy1;
  logic [0:0] load_data1, cap_data1;
  logic       chain1, chain1_val, chain1_load;

  int checks;
  int errors;

  scan_chain_loader #(
    .ChainLength(8)
  ) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .load_valid_i   (load_valid),
    .load_ready_o   (load_ready),
    .load_data_i    (load_data),
    .scan_en_o      (scan_en),
    .scan_d_o       (scan_d),
    .scan_q_i       (scan_q),
    .capture_valid_o(cap_valid),
    .capture_ready_i(cap_ready),
    .capture_data_o (cap_data),
    .busy_o         (busy)
  );

  scan_chain_loader #(
    .ChainLength(1)
  ) u_dut1 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .load_valid_i   (load_valid1),
    .load_ready_o   (load_ready1),
    .load_data_i    (load_data1),
    .scan_en_o      (scan_en1),
    .scan_d_o       (scan_d1),
    .scan_q_i       (scan_q1),
    .capture_valid_o(cap_valid1),
    .capture_ready_i(cap_ready1),
    .capture_data_o (cap_data1),
    .busy_o         (busy1)
  );

  // Chain models: position 0 takes scan_d, tail is position N-1.
  always @(posedge clk) begin
    if (chain_load) chain <= chain_val;
    else if (scan_en) chain <= {chain[6:0], scan_d};
    if (chain1_load) chain1 <= chain1_val;
    else if (scan_en1) chain1 <= scan_d1;
  end
  assign scan_q  = chain[7];
  assign scan_q1 = chain1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_phase(input logic [7:0] pat);
    for (int i = 1; i <= 8; i++) begin
      check("shift_en", 32'(scan_en), 1);
      check("shift_d", 32'(scan_d), 32'(pat[8-i]));
      check("shift_ready", 32'(load_ready), 0);
      check("shift_cvalid", 32'(cap_valid), 0);
      tick();
    end
  endtask

  initial begin
    logic seen_valid;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    load_valid = 1'b0; load_data = '0; cap_ready = 1'b0;
    chain_load = 1'b0; chain_val = '0;
    load_valid1 = 1'b0; load_data1 = '0; cap_ready1 = 1'b0;
    chain1_load = 1'b0; chain1_val = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_ready", 32'(load_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_en", 32'(scan_en), 0);
    check("rst_d", 32'(scan_d), 0);
    check("rst_cvalid", 32'(cap_valid), 0);
    check("rst_cdata", 32'(cap_data), 0);
    rst_n = 1'b1;

    // Load A5 into chain holding 3C
    chain_load = 1'b1; chain_val = 8'h3C;
    tick();
    chain_load = 1'b0;
    check("pre_chain", 32'(chain), 32'h3C);
    load_valid = 1'b1; load_data = 8'hA5;
    tick();
    load_valid = 1'b0;
    check("a5_busy", 32'(busy), 1);
    shift_phase(8'hA5);
    check("a5_en_off", 32'(scan_en), 0);
    check("a5_cvalid", 32'(cap_valid), 1);
    check("a5_cdata", 32'(cap_data), 32'h3C);
    check("a5_chain", 32'(chain), 32'hA5);

    // Backpressure with a competing load
    load_valid = 1'b1; load_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_cvalid", 32'(cap_valid), 1);
      check("bp_cdata", 32'(cap_data), 32'h3C);
      check("bp_ready", 32'(load_ready), 0);
      check("bp_en", 32'(scan_en), 0);
    end
    load_valid = 1'b0;
    cap_ready = 1'b1;
    tick();
    cap_ready = 1'b0;
    check("bp_rel_busy", 32'(busy), 0);
    check("bp_rel_cvalid", 32'(cap_valid), 0);
    check("bp_rel_ready", 32'(load_ready), 1);
    check("bp_chain", 32'(chain), 32'hA5);

    // Back-to-back: FF, then 00 raised together with capture_ready
    load_valid = 1'b1; load_data = 8'hFF;
    tick();
    load_valid = 1'b0;
    shift_phase(8'hFF);
    check("ff_cvalid", 32'(cap_valid), 1);
    check("ff_cdata", 32'(cap_data), 32'hA5);
    load_valid = 1'b1; load_data = 8'h00; cap_ready = 1'b1;
    tick();
    cap_ready = 1'b0;
    check("b2b_idle_busy", 32'(busy), 0);
    check("b2b_idle_ready", 32'(load_ready), 1);
    tick();
    load_valid = 1'b0;
    check("b2b_accept_busy", 32'(busy), 1);
    shift_phase(8'h00);
    check("b2b_cvalid", 32'(cap_valid), 1);
    check("b2b_cdata", 32'(cap_data), 32'hFF);
    check("b2b_chain", 32'(chain), 32'h00);
    cap_ready = 1'b1;
    tick();
    cap_ready = 1'b0;

    // Reset mid-shift after 3 shifts
    load_valid = 1'b1; load_data = 8'h5A;
    tick();
    load_valid = 1'b0;
    tick(); tick(); tick();
    check("mid_en_before", 32'(scan_en), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_en", 32'(scan_en), 0);
    check("mid_ready", 32'(load_ready), 1);
    check("mid_busy", 32'(busy), 0);
    check("mid_cdata", 32'(cap_data), 0);
    seen_valid = cap_valid;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen_valid = seen_valid | cap_valid | scan_en;
    end
    check("mid_no_capture", 32'(seen_valid), 0);

    // N = 1: load 1 into a cell holding 0
    chain1_load = 1'b1; chain1_val = 1'b0;
    tick();
    chain1_load = 1'b0;
    check("n1_ready", 32'(load_ready1), 1);
    load_valid1 = 1'b1; load_data1 = 1'b1;
    tick();
    load_valid1 = 1'b0;
    check("n1_en", 32'(scan_en1), 1);
    check("n1_d", 32'(scan_d1), 1);
    check("n1_cvalid_early", 32'(cap_valid1), 0);
    tick();
    check("n1_en_off", 32'(scan_en1), 0);
    check("n1_cvalid", 32'(cap_valid1), 1);
    check("n1_cdata", 32'(cap_data1), 0);
    check("n1_chain", 32'(chain1), 1);
    cap_ready1 = 1'b1;
    tick();
    cap_ready1 = 1'b0;
    check("n1_idle", 32'(busy1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
